trace_capture_buffer: RTL and testbench
=======================================

// Module: trace_capture_buffer
// PURPOSE
//  Hardware successor to bench-side $monitor tracing of the processor. Snoops the core's
//  per-cycle pc/instruction/alu_result/mem_write into a circular buffer of DEPTH entries.
//  Stops a programmable number of samples after a PC-match trigger.
//  Drains the capture oldest-first over a valid/ready port for on-chip debug.
// PARAMETERS
//  DATA_W    32  width of pc, instruction, alu_result fields
//  DEPTH     16  buffer entries; power of 2, >= 2
//  POST_TRIG 4   samples stored after the trigger sample; 0 <= POST_TRIG <= DEPTH-1
// PORTS
//  clk          in   1       single clock; all state updates on rising edge
//  rst          in   1       asynchronous, active-low reset
//  arm          in   1       1-cycle pulse: clear buffer, start capture
//  trig_pc      in   DATA_W  PC value that fires the trigger
//  smp_valid    in   1       sample qualifier (core retired an instruction this cycle)
//  pc           in   DATA_W  core pc
//  instruction  in   DATA_W  core instruction
//  alu_result   in   DATA_W  core alu_result
//  mem_write    in   1       core mem_write
//  rd_valid     out  1       readout entry available
//  rd_ready     in   1       consumer accepts entry when rd_valid && rd_ready
//  rd_pc        out  DATA_W  readout pc
//  rd_instr     out  DATA_W  readout instruction
//  rd_result    out  DATA_W  readout alu_result
//  rd_mem_write out  1       readout mem_write
//  rd_last      out  1       current readout entry is the final one
//  state        out  2       00 IDLE, 01 ARMED, 10 POST, 11 DONE
//  count        out  $clog2(DEPTH)+1  entries held, saturates at DEPTH
//  ovf_cnt      out  16      overwritten-sample count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=rd_ptr=0, count=0, post_cnt=0, ovf_cnt=0.
//   rd_valid=0, rd_last=0. rd_* data=0.
//  IDLE: nothing captured. arm -> ARMED; clears wr_ptr, count, ovf_cnt.
//  ARMED: on smp_valid, write {pc,instruction,alu_result,mem_write} at wr_ptr.
//   wr_ptr <= wr_ptr+1 mod DEPTH. count <= min(count+1, DEPTH).
//  Trigger: smp_valid && pc==trig_pc while ARMED.
//   Trigger sample is stored; post_cnt <= POST_TRIG.
//   Next state is POST, or DONE if POST_TRIG==0.
//  POST: each smp_valid sample stored as above; post_cnt decrements.
//   The write that takes post_cnt 1->0 moves to DONE on the same edge. PC matches are ignored.
//  smp_valid=0 cycles: no write, no count or post_cnt change, any state.
//  DONE: capture frozen; rd_ptr <= (wr_ptr - count) mod DEPTH on entry.
//   rd_valid=1 while entries remain; rd_* shows entry[rd_ptr] combinationally from the array.
//   rd_last=1 when one entry remains.
//   Handshake: rd_ptr+1 and remaining-1. Handshake on the rd_last entry -> IDLE, rd_valid=0 next cycle.
//   rd_ready low holds rd_* stable.
//  arm in ARMED/POST/DONE: abort and restart as from IDLE.
//   arm takes priority over a same-cycle trigger or sample; that cycle's sample is not stored.
//  Wrap-around: in ARMED, oldest entry is overwritten once count==DEPTH.
//   Total samples = pre-trigger + 1 + POST_TRIG; only the newest min(total, DEPTH) are retained.
//  Async reset mid-operation returns to reset values immediately, without waiting for clk.
//   Buffer contents are don't-care.
// CONFIGURATION
//  TRACE_OVERFLOW_CNT_EN defined:
//   ovf_cnt increments on each write that overwrites a live entry (count==DEPTH).
//   Saturates at 16'hFFFF; cleared by arm and reset.
//  Not defined: no counter logic; ovf_cnt tied to 0. The port is always present.
// TESTING  (DEPTH=16, POST_TRIG=4, smp_valid=1 every cycle, pc=0,4,8,...)
//  1 rst=0 mid-run -> state=00, count=0, rd_valid=0, ovf_cnt=0 without a clk edge.
//  2 arm, trig_pc=0x20 -> DONE after pc=0x30 stored, count=13.
//    Drain: rd_pc 0x00..0x30 step 4; rd_last only on 0x30; then state=00.
//  3 arm, trig_pc=0x80 -> 37 samples, count=16, drain rd_pc 0x54..0x90.
//    ovf_cnt=21 with macro, 0 without.
//  4 trig_pc=0x20, smp_valid low 3 cycles after trigger -> DONE still after exactly 4 valid post samples.
//  5 DONE, rd_ready low 5 cycles -> rd_valid=1, rd_pc stable at oldest entry; then drains normally.
//  6 arm and trigger-matching pc in the same cycle -> state=01, count=0; next matching sample triggers.

Source files
------------

// File: rtl/trace_capture_buffer.sv
// Circular trace buffer that snoops retired-instruction samples, stops a fixed number of
// samples after a PC-match trigger, and drains oldest-first over valid/ready.
// Optional macro TRACE_OVERFLOW_CNT_EN enables the overwritten-sample counter on ovf_cnt.
module trace_capture_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic                     smp_valid,
  input  logic [DATA_W-1:0]        pc,
  input  logic [DATA_W-1:0]        instruction,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     mem_write,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_instr,
  output logic [DATA_W-1:0]        rd_result,
  output logic                     rd_mem_write,
  output logic                     rd_last,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              ovf_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam bit          NO_POST = (POST_TRIG == 0);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] result;
    logic              mem_write;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   post_cnt_q, post_cnt_d;
  logic               wr_en_c;
  logic               full_c;
  entry_t             wr_entry_c;
  entry_t             rd_entry_c;
  entry_t             mem_q [DEPTH];

  assign full_c     = (count_q == CNT_W'(DEPTH));
  assign wr_entry_c = '{pc: pc, instr: instruction, result: alu_result, mem_write: mem_write};

  // Next-state, pointer and occupancy logic; arm overrides everything else that cycle.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    wr_en_c    = 1'b0;

    if (arm) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ARMED, S_POST: begin
          if (smp_valid) begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = full_c ? count_q : count_q + CNT_W'(1);
            if (state_q == S_ARMED) begin
              if (pc == trig_pc) begin
                post_cnt_d = PTR_W'(POST_TRIG);
                state_d    = NO_POST ? S_DONE : S_POST;
              end
            end else begin
              post_cnt_d = post_cnt_q - PTR_W'(1);
              if (post_cnt_q == PTR_W'(1)) state_d = S_DONE;
            end
            // Oldest retained entry sits count entries behind the write pointer.
            if (state_d == S_DONE) rd_ptr_d = wr_ptr_d - PTR_W'(count_d);
          end
        end
        S_DONE: begin
          if (rd_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  // Sample storage has no reset; contents are only observed after being written.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= wr_entry_c;
  end

`ifdef TRACE_OVERFLOW_CNT_EN
  logic [15:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (arm) begin
      ovf_d = '0;
    end else if (wr_en_c && full_c && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= '0;
    else      ovf_q <= ovf_d;
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = '0;
`endif

  // Readout is a direct array view, forced to zero whenever no entry is offered.
  assign rd_entry_c   = mem_q[rd_ptr_q];
  assign rd_valid     = (state_q == S_DONE);
  assign rd_last      = (state_q == S_DONE) && (count_q == CNT_W'(1));
  assign rd_pc        = rd_valid ? rd_entry_c.pc        : '0;
  assign rd_instr     = rd_valid ? rd_entry_c.instr     : '0;
  assign rd_result    = rd_valid ? rd_entry_c.result    : '0;
  assign rd_mem_write = rd_valid ? rd_entry_c.mem_write : 1'b0;

  assign state = state_q;
  assign count = count_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer (DEPTH=16, POST_TRIG=4), samples pc=4*i.
module tb_trace_capture_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic [31:0] trig_pc;
  logic        smp_valid;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] alu_result;
  logic        mem_write;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [31:0] rd_result;
  logic        rd_mem_write;
  logic        rd_last;
  logic [1:0]  state;
  logic [4:0]  count;
  logic [15:0] ovf_cnt;

  int checks = 0;
  int errors = 0;

  trace_capture_buffer #(.DATA_W(32), .DEPTH(16), .POST_TRIG(4)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_pc(trig_pc), .smp_valid(smp_valid),
    .pc(pc), .instruction(instruction), .alu_result(alu_result), .mem_write(mem_write),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_result(rd_result), .rd_mem_write(rd_mem_write), .rd_last(rd_last),
    .state(state), .count(count), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input logic [31:0] p);
    pc          = p;
    instruction = 32'h1000_0000 | p;
    alu_result  = ~p;
    mem_write   = p[2];
  endtask

  task automatic arm_pulse(input logic [31:0] t);
    trig_pc   = t;
    arm       = 1'b1;
    smp_valid = 1'b0;
    tick();
    arm       = 1'b0;
  endtask

  // Feeds n valid samples with pc = 4*first .. 4*(first+n-1).
  task automatic feed(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      set_sample(32'(i * 4));
      smp_valid = 1'b1;
      tick();
    end
    smp_valid = 1'b0;
  endtask

  task automatic drain(input logic [31:0] first, input int n);
    logic [31:0] p;
    rd_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      p = first + 32'(4 * k);
      chk("drain_valid", 32'(rd_valid), 32'd1);
      chk("drain_pc", rd_pc, p);
      chk("drain_last", 32'(rd_last), 32'(k == n - 1));
      if (k == 1) begin
        chk("drain_instr", rd_instr, 32'h1000_0000 | p);
        chk("drain_result", rd_result, ~p);
        chk("drain_memw", 32'(rd_mem_write), 32'(p[2]));
      end
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_end_state", 32'(state), 32'd0);
    chk("drain_end_valid", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0; arm = 1'b0; trig_pc = '0; smp_valid = 1'b0; rd_ready = 1'b0;
    set_sample(32'h0);
    #2;
    chk("por_state", 32'(state), 32'd0);
    chk("por_count", 32'(count), 32'd0);
    chk("por_rd_valid", 32'(rd_valid), 32'd0);
    chk("por_rd_pc", rd_pc, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Trigger at 0x20, four post samples, 13 retained.
    arm_pulse(32'h20);
    chk("armed_state", 32'(state), 32'd1);
    feed(0, 12);
    chk("post_state", 32'(state), 32'd2);
    feed(12, 1);
    chk("done_state", 32'(state), 32'd3);
    chk("done_count", 32'(count), 32'd13);
    drain(32'h0, 13);

    // Wrap-around: 37 samples, newest 16 kept.
    arm_pulse(32'h80);
    feed(0, 37);
    chk("wrap_state", 32'(state), 32'd3);
    chk("wrap_count", 32'(count), 32'd16);
`ifdef TRACE_OVERFLOW_CNT_EN
    chk("wrap_ovf", 32'(ovf_cnt), 32'd21);
`else
    chk("wrap_ovf", 32'(ovf_cnt), 32'd0);
`endif
    drain(32'h54, 16);

    // Gaps in smp_valid after the trigger do not consume post samples.
    arm_pulse(32'h20);
    feed(0, 9);
    chk("gap_post_state", 32'(state), 32'd2);
    tick(); tick(); tick();
    chk("gap_hold_state", 32'(state), 32'd2);
    chk("gap_hold_count", 32'(count), 32'd9);
    feed(9, 3);
    chk("gap_pre_done", 32'(state), 32'd2);
    feed(12, 1);
    chk("gap_done_state", 32'(state), 32'd3);
    chk("gap_done_count", 32'(count), 32'd13);

    // Back-pressure holds the oldest entry on the port.
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(rd_valid), 32'd1);
      chk("stall_pc", rd_pc, 32'h0);
      tick();
    end
    drain(32'h0, 13);

    // arm wins over a same-cycle trigger match.
    trig_pc   = 32'h20;
    set_sample(32'h20);
    smp_valid = 1'b1;
    arm       = 1'b1;
    tick();
    arm       = 1'b0;
    smp_valid = 1'b0;
    chk("armtrig_state", 32'(state), 32'd1);
    chk("armtrig_count", 32'(count), 32'd0);
    feed(8, 1);
    chk("armtrig_post", 32'(state), 32'd2);
    chk("armtrig_count1", 32'(count), 32'd1);
    feed(9, 4);
    chk("armtrig_done", 32'(state), 32'd3);
    drain(32'h20, 5);

    // Asynchronous reset mid-capture, checked before any clock edge.
    arm_pulse(32'h40);
    feed(0, 20);
    chk("pre_rst_count", 32'(count), 32'd16);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_ovf", 32'(ovf_cnt), 32'd0);
    chk("arst_rd_last", 32'(rd_last), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_idle", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
